// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI register target.
package spi_target_pkg;
  localparam int ADDR_W       = 4;
  localparam int CMD_READ_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA
  } state_t;
endpackage

// File: rtl/sync_edge.sv
// N-stage synchronizer with registered rise/fall pulses aligned to the synced output.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic [STAGES-1:0] r_vld;
  logic              r_rise;
  logic              r_fall;

  // Pulses are suppressed until every stage holds a real sample, so the
  // reset fill value never produces a phantom edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_vld  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_vld  <= {r_vld[STAGES-2:0], 1'b1};
      r_rise <= r_vld[STAGES-1] &  r_sync[STAGES-2] & ~r_sync[STAGES-1];
      r_fall <= r_vld[STAGES-1] & ~r_sync[STAGES-2] &  r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = r_rise;
  assign o_fall = r_fall;
endmodule

// File: rtl/spi_target_regs.sv
// SPI mode-0 target with a flop-based register bank, oversampled in the clk domain.
module spi_target_regs
  import spi_target_pkg::*;
#(
  parameter int         NREGS       = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [7:0]        host_data,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);
  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(NREGS - 1);

  state_t r_state, w_next;

  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic w_sck_sync_unused, w_sck_rise, w_sck_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  logic [2:0]        r_bitcnt;
  logic [7:0]        r_rx_sr;
  logic [7:0]        r_tx_sr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_miso;
  logic              r_miso_oe;
  logic [7:0]        r_host_data;
  logic              r_wr_strobe;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [7:0]        r_regs [NREGS];

  logic [7:0]        w_rx_byte;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [ADDR_W-1:0] w_ld_addr;
  logic w_start, w_rx_en, w_byte_done, w_cmd_done, w_wr_byte, w_rd_load, w_tx_en;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .i_d(spi_cs_n),
    .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .i_d(spi_sck),
    .o_sync(w_sck_sync_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mosi_sync <= '0;
    else     r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
  end

  assign w_rx_byte  = {r_rx_sr[6:0], r_mosi_sync[SYNC_STAGES-1]};
  assign w_cmd_addr = w_rx_byte[ADDR_W-1:0] & AMASK;
  assign w_ld_addr  = (r_state == ST_CMD) ? w_cmd_addr : r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_cs_fall) w_next = ST_CMD;
      ST_CMD:  if (w_sck_rise && r_bitcnt == 3'd7)
                 w_next = w_rx_byte[CMD_READ_BIT] ? ST_RDATA : ST_WDATA;
      default: ;
    endcase
    if (w_cs_rise) w_next = ST_IDLE;
  end

  always_comb begin
    w_start     = (r_state == ST_IDLE) && w_cs_fall;
    w_rx_en     = (r_state != ST_IDLE) && w_sck_rise;
    w_byte_done = w_rx_en && (r_bitcnt == 3'd7);
    w_cmd_done  = w_byte_done && (r_state == ST_CMD);
    w_wr_byte   = w_byte_done && (r_state == ST_WDATA);
    w_rd_load   = (w_cmd_done && w_rx_byte[CMD_READ_BIT]) ||
                  (w_byte_done && (r_state == ST_RDATA));
    w_tx_en     = (r_state == ST_RDATA) && w_sck_fall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt    <= '0;
      r_rx_sr     <= '0;
      r_tx_sr     <= '0;
      r_addr      <= '0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_host_data <= RESET_VAL;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= RESET_VAL;
    end else begin
      r_miso_oe   <= ~w_cs_sync;
      r_wr_strobe <= 1'b0;
      r_host_data <= r_regs[host_addr & AMASK];
      if (w_start) begin
        r_bitcnt <= '0;
        r_rx_sr  <= '0;
        r_tx_sr  <= '0;
        r_miso   <= 1'b0;
      end else if (w_rx_en) begin
        r_rx_sr  <= w_rx_byte;
        r_bitcnt <= r_bitcnt + 3'd1;
        if (w_rd_load) begin
          r_tx_sr <= r_regs[w_ld_addr];
          r_addr  <= (w_ld_addr + 1'b1) & AMASK;
        end else if (w_cmd_done) begin
          r_addr <= w_cmd_addr;
        end else if (w_wr_byte) begin
          r_regs[r_addr] <= w_rx_byte;
          r_wr_strobe    <= 1'b1;
          r_wr_addr      <= r_addr;
          r_wr_data      <= w_rx_byte;
          r_addr         <= (r_addr + 1'b1) & AMASK;
        end
      end else if (w_tx_en) begin
        r_miso  <= r_tx_sr[7];
        r_tx_sr <= {r_tx_sr[6:0], 1'b0};
      end
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_miso_oe;
  assign host_data   = r_host_data;
  assign wr_strobe   = r_wr_strobe;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
endmodule

// File: tb/tb_spi_target_regs.sv
// Randomized bench for spi_target_regs against a transaction-level register model.
module tb_spi_target_regs;
  localparam int S    = 2;
  localparam int HALF = S + 2;

  logic       clk = 1'b0;
  logic       rst, sck, mosi, cs_n;
  logic       miso, miso_oe, wr_strobe;
  logic [3:0] host_addr, wr_addr;
  logic [7:0] host_data, wr_data;

  always #5 clk = ~clk;

  spi_target_regs #(.NREGS(16), .SYNC_STAGES(S), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .spi_sck(sck), .spi_mosi(mosi), .spi_cs_n(cs_n),
    .spi_miso(miso), .spi_miso_oe(miso_oe),
    .host_addr(host_addr), .host_data(host_data),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] model [16];
  wr_t        exp_q [$];
  bit         host_chk_en = 1'b0;
  bit         host_rand   = 1'b1;
  bit         prev_en     = 1'b0;
  logic [3:0] prev_addr   = '0;
  logic [7:0] tx_bytes [8];
  logic [7:0] rx_bytes [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCK period per bit: low phase (MISO sampled at its end), then high phase.
  task automatic xfer_byte(input logic [7:0] tx, input int nbits, input bit push_wr,
                           input logic [3:0] wa, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      if (push_wr && i == 7) exp_q.push_back('{a: wa, d: tx});
      cyc(HALF);
      rx = {rx[6:0], miso};
      sck = 1'b1;
      cyc(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic run_txn(input logic [7:0] cmd, input int ndata, input int last_bits);
    logic [3:0] a;
    logic [7:0] r;
    bit         rd;
    int         nb;
    host_chk_en = 1'b0;
    a  = cmd[3:0];
    rd = cmd[7];
    cs_n = 1'b0;
    cyc(HALF + 2);
    check("miso_oe_selected", miso_oe, 1'b1);
    xfer_byte(cmd, 8, 1'b0, 4'h0, r);
    check("miso_during_cmd", r, 8'h00);
    for (int k = 0; k < ndata; k++) begin
      nb = (k == ndata - 1) ? last_bits : 8;
      xfer_byte(tx_bytes[k], nb, !rd && nb == 8, a, r);
      rx_bytes[k] = r;
      if (nb == 8) begin
        if (rd) check("read_byte", r, model[a]);
        else begin
          check("miso_during_write", r, 8'h00);
          model[a] = tx_bytes[k];
        end
        a = a + 4'd1;
      end
    end
    cyc(2);
    cs_n = 1'b1;
    cyc(HALF + 4);
    check("miso_oe_deselected", miso_oe, 1'b0);
    host_chk_en = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (host_rand) host_addr = 4'($urandom);
    end
  end

  always @(negedge clk) begin
    if (wr_strobe) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL wr_strobe_unexpected: got addr %0h data %0h expected no strobe", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e.a);
        check("wr_data", wr_data, e.d);
      end
    end
    if (host_chk_en && prev_en) check("host_data", host_data, model[prev_addr]);
    prev_en   = host_chk_en && !rst;
    prev_addr = host_addr;
  end

  initial begin
    logic [7:0] r;
    logic [7:0] cmd;
    int         nd, lb;
    rst = 1'b1; sck = 1'b0; mosi = 1'b0; cs_n = 1'b1; host_addr = '0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    cyc(3);
    check("rst_miso", miso, 1'b0);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_host_data", host_data, 8'h00);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_wr_addr", wr_addr, 4'h0);
    check("rst_wr_data", wr_data, 8'h00);
    rst = 1'b0;
    cyc(S + 4);
    host_chk_en = 1'b1;

    tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h5A;
    run_txn(8'h03, 2, 8);
    host_rand = 1'b0; host_addr = 4'h3; cyc(2);
    check("lit_reg3", host_data, 8'hA5);
    host_addr = 4'h4; cyc(2);
    check("lit_reg4", host_data, 8'h5A);
    host_rand = 1'b1;

    run_txn(8'h83, 2, 8);
    check("lit_read0", rx_bytes[0], 8'hA5);
    check("lit_read1", rx_bytes[1], 8'h5A);

    tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22;
    run_txn(8'h0F, 2, 8);
    run_txn(8'h8F, 2, 8);
    check("lit_wrap0", rx_bytes[0], 8'h11);
    check("lit_wrap1", rx_bytes[1], 8'h22);

    tx_bytes[0] = 8'hFF; tx_bytes[1] = 8'b1011_0000;
    run_txn(8'h02, 2, 5);
    host_rand = 1'b0; host_addr = 4'h2; cyc(2);
    check("lit_abort_reg2", host_data, 8'hFF);
    host_addr = 4'h3; cyc(2);
    check("lit_abort_reg3", host_data, 8'hA5);
    host_rand = 1'b1;
    run_txn(8'hB3, 1, 8);
    check("lit_after_abort", rx_bytes[0], 8'hA5);

    tx_bytes[0] = 8'h3C;
    run_txn(8'h07, 1, 8);
    host_rand = 1'b0; host_addr = 4'h7; cyc(1);
    check("lit_host_port", host_data, 8'h3C);
    host_rand = 1'b1;

    for (int t = 0; t < 24; t++) begin
      cmd = 8'($urandom);
      nd  = int'($urandom_range(1, 4));
      lb  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8;
      for (int k = 0; k < 8; k++) tx_bytes[k] = 8'($urandom);
      run_txn(cmd, nd, lb);
    end

    host_chk_en = 1'b0;
    cs_n = 1'b0;
    cyc(HALF + 2);
    xfer_byte(8'h05, 8, 1'b0, 4'h0, r);
    xfer_byte(8'hC3, 3, 1'b0, 4'h0, r);
    mosi = 1'b1;
    sck  = 1'b1;
    cyc(2);
    rst = 1'b1;
    #1;
    check("arst_miso", miso, 1'b0);
    check("arst_miso_oe", miso_oe, 1'b0);
    check("arst_host_data", host_data, 8'h00);
    check("arst_wr_strobe", wr_strobe, 1'b0);
    check("arst_wr_addr", wr_addr, 4'h0);
    check("arst_wr_data", wr_data, 8'h00);
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    cyc(2);
    sck = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(S + 3);
    xfer_byte(8'h00, 5, 1'b0, 4'h0, r);
    xfer_byte(8'hEE, 8, 1'b0, 4'h0, r);
    cyc(2);
    cs_n = 1'b1;
    cyc(HALF + 4);
    check("arst_oe_after", miso_oe, 1'b0);
    host_chk_en = 1'b1;
    host_rand = 1'b0; host_addr = 4'h5; cyc(2);
    check("lit_reset_reg5", host_data, 8'h00);
    host_rand = 1'b1;
    tx_bytes[0] = 8'h77;
    run_txn(8'h05, 1, 8);
    run_txn(8'h85, 1, 8);
    check("lit_post_reset", rx_bytes[0], 8'h77);

    cyc(10);
    check("strobes_outstanding", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
